data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
Parametrised single-port data memory with a valid/ready request interface, a configurable read-pipeline latency and out-of-range address detection. An optional post-reset sweep clears the array to zero. It replaces the fixed 19-bit x 512 data memory on the 19-bit processor's load/store path. Every accepted request, read or write, returns exactly one response after a fixed latency.

Parameters:
DATA_W, 19, data word width in bits
ADDR_W, 19, request address width in bits
DEPTH, 512, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W
RD_LAT, 1, cycles from request acceptance to response; legal range 1..4
CLEAR_ON_RESET, 1, 1 = zero-fill the whole array after reset; 0 = array contents are left undefined

Ports:
clk  input  1  clock; all logic is on the rising edge
reset  input  1  synchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  response valid; there is no backpressure
rsp_rdata  output  DATA_W  read data; 0 for writes and for errors
rsp_err  output  1  address was out of range (req_addr >= DEPTH)
init_busy  output  1  zero-fill sweep in progress

Behaviour:
- Reset is synchronous and active-high: while reset is sampled high, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_busy=CLEAR_ON_RESET, FSM goes to ST_INIT, init counter=0.
- Reset mid-operation flushes every in-flight response. Nothing pending is emitted after reset.
- ST_INIT, CLEAR_ON_RESET=1:
  - writes 0 to address init_cnt on every cycle; init_cnt increments each cycle.
  - after writing DEPTH-1, goes to ST_RUN. The sweep takes exactly DEPTH cycles after reset deasserts.
  - init_busy=1 and req_ready=0 throughout.
- ST_INIT, CLEAR_ON_RESET=0: goes to ST_RUN on the first cycle after reset deasserts.
- ST_RUN: req_ready=1 and init_busy=0. The FSM has no further transitions except reset.
- Acceptance happens on an edge where req_valid && req_ready.
- Accepted write, addr < DEPTH: mem[addr] is updated at the acceptance edge. Response has rdata=0, err=0.
- Accepted read, addr < DEPTH: mem[addr] is sampled at the acceptance edge. Response has rdata=that value, err=0.
- Accepted request, addr >= DEPTH: no array access. Response has rdata=0, err=1.
- Latency: a request accepted in cycle c has rsp_valid=1 in cycle c+RD_LAT, for exactly one cycle.
- Full throughput: one request per cycle, with no bubbles.
- Read-after-write: a write accepted in cycle c is visible to a read accepted in cycle c+1 or later.
- Reads accepted before a write keep their sampled data even if the write lands while they are still in the pipe.
- Address comparison is unsigned and ADDR_W wide. Indexing uses only the low clog2(DEPTH) bits, and only after the range check has passed.
- req_valid while req_ready=0 is ignored, with no response. Requesters must hold the request until it is accepted.
- Outputs are registered: rsp_* and init_busy come from flops; req_ready is decoded from FSM state.
- Elaboration error if RD_LAT is outside 1..4 or DEPTH > 2**ADDR_W.

Decomposition:
- Package mem_pkg holds:
  - the FSM state enum (ST_INIT, ST_RUN);
  - default DATA_W/ADDR_W/DEPTH/RD_LAT constants;
  - the RD_LAT_MAX=4 constant.
- One sub-module, rsp_pipe: a delay line of RD_LAT-1 stages for {valid, err, rdata}. Valid flops are reset; data flops are not.

Test Plan:
- Reset then sweep, CLEAR_ON_RESET=1, DEPTH=512 -> init_busy=1 and req_ready=0 for exactly 512 cycles; after that, a read of addr 37 returns rdata=0, err=0.
- Write addr 0=123 then read addr 0; write addr 1=456 then read addr 1 (RD_LAT=1) -> read responses carry 123 and 456, each with rsp_valid one cycle after acceptance.
- Back-to-back write addr 5=0x7FFFF followed next cycle by read addr 5, RD_LAT=3 -> read response has rdata=0x7FFFF, exactly 3 cycles after its acceptance.
- Read addr 512 and write addr 600 with DEPTH=512 -> both responses have err=1, rdata=0; mem[0] and mem[88] are unchanged.
- Four reads accepted on consecutive cycles, RD_LAT=4, addrs 0..3 preloaded with 10,11,12,13 -> rsp_valid high for 4 consecutive cycles, in order, carrying 10,11,12,13.
- Reset asserted while two reads are in flight (RD_LAT=2) -> rsp_valid stays 0 and no stale response appears; the sweep restarts.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default sizing for the data memory controller.
package mem_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  localparam int unsigned DATA_W_DEF = 19;
  localparam int unsigned ADDR_W_DEF = 19;
  localparam int unsigned DEPTH_DEF  = 512;
  localparam int unsigned RD_LAT_DEF = 1;
  localparam int unsigned RD_LAT_MAX = 4;

endpackage

// File: rtl/rsp_pipe.sv
// Delay line for {valid, err, rdata}; only the valid bits are reset.
module rsp_pipe #(
  parameter int unsigned STAGES = 0,
  parameter int unsigned DATA_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_rdata,
  output logic              out_valid,
  output logic              out_err,
  output logic [DATA_W-1:0] out_rdata
);

  if (STAGES == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = clk ^ reset;
    assign out_valid = in_valid;
    assign out_err   = in_err;
    assign out_rdata = in_rdata;
  end else begin : g_pipe
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] err_q;
    logic [DATA_W-1:0] rdata_q [STAGES];

    // Valid chain: flushed by reset so no stale response survives
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= '0;
      end else begin
        valid_q[0] <= in_valid;
        for (int i = 1; i < int'(STAGES); i++) begin
          valid_q[i] <= valid_q[i-1];
        end
      end
    end

    // Payload chain: unreset, qualified by valid downstream
    always_ff @(posedge clk) begin
      err_q[0]   <= in_err;
      rdata_q[0] <= in_rdata;
      for (int i = 1; i < int'(STAGES); i++) begin
        err_q[i]   <= err_q[i-1];
        rdata_q[i] <= rdata_q[i-1];
      end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_err   = err_q[STAGES-1];
    assign out_rdata = rdata_q[STAGES-1];
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Single-port data memory with valid/ready requests, fixed response latency,
// out-of-range detection and an optional zero-fill sweep after reset.
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DEPTH          = DEPTH_DEF,
  parameter int unsigned RD_LAT         = RD_LAT_DEF,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_busy
);

  localparam int unsigned       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("RD_LAT must be within 1..%0d", RD_LAT_MAX);
  end
  if (DEPTH < 1 || (ADDR_W < 32 && longint'(DEPTH) > (longint'(1) << ADDR_W))) begin : g_bad_depth
    $error("DEPTH must be within 1..2**ADDR_W");
  end

  state_e            state_q;
  logic [IDX_W-1:0]  init_cnt_q;
  logic              init_busy_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              sweep_wr;
  logic              acc_err;
  logic [DATA_W-1:0] acc_rdata;
  logic              p_valid;
  logic              p_err;
  logic [DATA_W-1:0] p_rdata;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  // Ready is dropped combinationally during reset so nothing lands on a reset edge
  assign req_ready = (state_q == ST_RUN) && !reset;
  assign accept    = req_valid && req_ready;
  assign in_range  = {1'b0, req_addr} < DEPTH_X;
  assign idx       = req_addr[IDX_W-1:0];
  assign sweep_wr  = (state_q == ST_INIT) && CLEAR_ON_RESET && !reset;
  assign acc_err   = accept && !in_range;
  assign acc_rdata = (accept && !req_write && in_range) ? mem[idx] : '0;

  // Init/run FSM with the sweep counter and registered busy flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_busy_q <= CLEAR_ON_RESET;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + IDX_W'(1);
          if (!CLEAR_ON_RESET || init_cnt_q == LAST_IDX) begin
            state_q     <= ST_RUN;
            init_busy_q <= 1'b0;
          end
        end
        ST_RUN:  ;
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // Array write port: sweep zeros while initialising, in-range writes while running
  always_ff @(posedge clk) begin
    if (sweep_wr) begin
      mem[init_cnt_q] <= '0;
    end else if (accept && req_write && in_range) begin
      mem[idx] <= req_wdata;
    end
  end

  rsp_pipe #(
    .STAGES (RD_LAT - 1),
    .DATA_W (DATA_W)
  ) u_rsp_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (accept),
    .in_err    (acc_err),
    .in_rdata  (acc_rdata),
    .out_valid (p_valid),
    .out_err   (p_err),
    .out_rdata (p_rdata)
  );

  // Final response stage; zeroes payload when idle so unreset pipe data never leaks
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= p_valid;
      rsp_err_q   <= p_valid && p_err;
      rsp_rdata_q <= p_valid ? p_rdata : '0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_busy = init_busy_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Four controllers (RD_LAT 1..4) share one request stream; a scoreboard of
// expected responses is checked per lane at its own latency.
module tb_data_memory_ctrl;

  localparam int NL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [18:0] req_addr = '0;
  logic [18:0] req_wdata = '0;

  logic [NL-1:0] req_ready;
  logic [NL-1:0] rsp_valid;
  logic [NL-1:0] rsp_err;
  logic [NL-1:0] init_busy;
  logic [18:0]   rsp_rdata [NL];

  typedef struct {
    int          cyc;
    logic        err;
    logic [18:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          ptrs[NL];
  int          ncyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [18:0] model [512];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : g_dut
    data_memory_ctrl #(
      .DATA_W         (19),
      .ADDR_W         (19),
      .DEPTH          (512),
      .RD_LAT         (g + 1),
      .CLEAR_ON_RESET (1'b1)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready[g]),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .init_busy (init_busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Response monitor: every lane, every cycle
  initial begin : mon
    logic ev;
    exp_t e;
    forever begin
      @(negedge clk);
      ncyc++;
      for (int l = 0; l < NL; l++) begin
        ev = (ptrs[l] < sb.size()) && (sb[ptrs[l]].cyc + l + 1 == ncyc);
        chk($sformatf("lat%0d rsp_valid", l + 1), 32'(rsp_valid[l]), 32'(ev));
        if (ev) begin
          e = sb[ptrs[l]];
          chk($sformatf("lat%0d rsp_rdata", l + 1), 32'(rsp_rdata[l]), 32'(e.rdata));
          chk($sformatf("lat%0d rsp_err", l + 1), 32'(rsp_err[l]), 32'(e.err));
          ptrs[l]++;
        end
      end
    end
  end

  task automatic issue(input logic w, input int a, input logic [18:0] d);
    exp_t e;
    @(negedge clk);
    #1;
    for (int l = 0; l < NL; l++) chk($sformatf("lat%0d req_ready", l + 1), 32'(req_ready[l]), 1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = 19'(a);
    req_wdata = d;
    e.cyc   = ncyc;
    e.err   = (a >= 512);
    e.rdata = '0;
    if (!e.err) begin
      if (w) model[a] = d;
      else   e.rdata = model[a];
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset     = 1'b1;
    req_valid = 1'b0;
    sb.delete();
    ptrs = '{default: 0};
    foreach (model[i]) model[i] = '0;
    repeat (2) @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("lat%0d reset req_ready", l + 1), 32'(req_ready[l]), 0);
      chk($sformatf("lat%0d reset init_busy", l + 1), 32'(init_busy[l]), 1);
      chk($sformatf("lat%0d reset rsp_rdata", l + 1), 32'(rsp_rdata[l]), 0);
      chk($sformatf("lat%0d reset rsp_err", l + 1), 32'(rsp_err[l]), 0);
    end
    #1;
    reset = 1'b0;
    for (int k = 1; k < 512; k++) begin
      @(negedge clk);
      for (int l = 0; l < NL; l++) begin
        chk($sformatf("lat%0d sweep init_busy", l + 1), 32'(init_busy[l]), 1);
        chk($sformatf("lat%0d sweep req_ready", l + 1), 32'(req_ready[l]), 0);
      end
      // A request during the sweep must be ignored
      if (k == 100) begin
        #1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 19'd37;
      end
      if (k == 110) begin
        #1;
        req_valid = 1'b0;
      end
    end
    @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("lat%0d run init_busy", l + 1), 32'(init_busy[l]), 0);
      chk($sformatf("lat%0d run req_ready", l + 1), 32'(req_ready[l]), 1);
    end
  endtask

  initial begin
    do_reset();
    issue(1'b0, 37, '0);
    issue(1'b1, 0, 19'd123);
    issue(1'b0, 0, '0);
    issue(1'b1, 1, 19'd456);
    issue(1'b0, 1, '0);
    issue(1'b1, 5, 19'h7FFFF);
    issue(1'b0, 5, '0);
    issue(1'b0, 512, '0);
    issue(1'b1, 600, 19'h1234);
    issue(1'b1, 512, 19'h2222);
    issue(1'b0, 'h7FFFF, '0);
    issue(1'b0, 0, '0);
    issue(1'b0, 88, '0);
    idle(2);
    issue(1'b1, 0, 19'd10);
    issue(1'b1, 1, 19'd11);
    issue(1'b1, 2, 19'd12);
    issue(1'b1, 3, 19'd13);
    idle(1);
    issue(1'b0, 0, '0);
    issue(1'b0, 1, '0);
    issue(1'b0, 2, '0);
    issue(1'b0, 3, '0);
    // Read sampled before a later write must keep the old value
    issue(1'b0, 2, '0);
    issue(1'b1, 2, 19'd99);
    issue(1'b0, 2, '0);
    idle(6);
    // Reads in flight when reset hits are flushed; sweep restarts
    issue(1'b0, 1, '0);
    issue(1'b0, 3, '0);
    do_reset();
    issue(1'b0, 0, '0);
    issue(1'b0, 5, '0);
    issue(1'b0, 511, '0);
    idle(8);
    for (int l = 0; l < NL; l++) chk($sformatf("lat%0d drained", l + 1), 32'(ptrs[l]), 32'(sb.size()));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
